// File: rtl/stereo_frame_feeder_pkg.sv
// Shared frame geometry and state encodings for the stereo frame feeder.
// Geometry defaults must match the disparity engine's frame size.
package stereo_frame_feeder_pkg;

  localparam int DEF_SRC_WIDTH  = 640;
  localparam int DEF_SRC_HEIGHT = 480;
  localparam int DEF_SCALE      = 16;
  localparam int DEF_WIDTH      = DEF_SRC_WIDTH / DEF_SCALE;
  localparam int DEF_HEIGHT     = DEF_SRC_HEIGHT / DEF_SCALE;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_ACTIVE
  } cap_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ROW,
    R_GAP,
    R_DONE
  } rd_state_e;

  function automatic int cw(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/stereo_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// No reset on storage or read data so it maps onto block RAM.
module stereo_frame_ram #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/stereo_frame_feeder.sv
// Captures decimated left/right camera frames and streams one back
// on request to the disparity engine.
module stereo_frame_feeder
  import stereo_frame_feeder_pkg::*;
#(
  parameter int SRC_WIDTH  = DEF_SRC_WIDTH,
  parameter int SRC_HEIGHT = DEF_SRC_HEIGHT,
  parameter int SCALE      = DEF_SCALE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  input  logic       cam_side,
  input  logic       image_sel,
  input  logic       rd_req,
  output logic [7:0] image_data,
  output logic       buffer_ready,
  output logic       buffer_href,
  output logic       buffer_vref,
  output logic [1:0] frame_valid,
  output logic       rd_busy,
  output logic [7:0] drop_cnt
);

  localparam int WIDTH  = SRC_WIDTH / SCALE;
  localparam int HEIGHT = SRC_HEIGHT / SCALE;
  localparam int FRAME  = WIDTH * HEIGHT;
  localparam int DEPTH  = 2 * FRAME;
  localparam int AW     = $clog2(DEPTH);
  localparam int SUBW   = cw(SCALE - 1);
  localparam int CW     = cw(WIDTH);
  localparam int RW     = cw(HEIGHT);

  cap_state_e      cap_q, cap_d;
  logic            side_q, side_d;
  logic [SUBW-1:0] csub_q, csub_d;
  logic [SUBW-1:0] rsub_q, rsub_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      fv_q, fv_d;
  logic [7:0]      drop_q, drop_d;
  logic            vsync_q, href_q;

  rd_state_e       rst_q, rst_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [CW-1:0]   rcol_q, rcol_d;
  logic [RW-1:0]   rrow_q, rrow_d;
  logic            ready_q, vref_q;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      rdata;
  logic            vs_fall, vs_rise, href_fall, pix, rd_accept;

  assign vs_fall   = vsync_q & ~cam_vsync;
  assign vs_rise   = ~vsync_q & cam_vsync;
  assign href_fall = href_q & ~cam_href;
  assign pix       = cam_valid & cam_href;
  assign rd_busy   = (rst_q != R_IDLE);
  assign rd_accept = (rst_q == R_IDLE) & rd_req & fv_q[image_sel];

  assign waddr = ((side_q == SIDE_RIGHT) ? AW'(FRAME) : AW'(0))
               + AW'(row_q) * AW'(WIDTH) + AW'(col_q);

  always_comb begin
    cap_d  = cap_q;
    side_d = side_q;
    csub_d = csub_q;
    rsub_d = rsub_q;
    col_d  = col_q;
    row_d  = row_q;
    fv_d   = fv_q;
    drop_d = drop_q;
    we     = 1'b0;
    unique case (cap_q)
      C_IDLE: begin
        if (vs_fall) begin
          side_d = cam_side;
          csub_d = '0;
          rsub_d = '0;
          col_d  = '0;
          row_d  = '0;
          // A readout accepted this same cycle takes priority
          if (rd_busy || rd_accept) begin
            cap_d = C_WAIT;
          end else begin
            cap_d = C_ACTIVE;
            fv_d[cam_side] = 1'b0;
          end
        end
      end
      C_WAIT: begin
        if (vs_rise) begin
          drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
          cap_d  = C_IDLE;
        end
      end
      C_ACTIVE: begin
        if (pix && (col_q < CW'(WIDTH))) begin
          we = (csub_q == '0) && (rsub_q == '0);
          if (csub_q == SUBW'(SCALE - 1)) begin
            csub_d = '0;
            col_d  = col_q + CW'(1);
          end else begin
            csub_d = csub_q + SUBW'(1);
          end
        end
        if (href_fall) begin
          csub_d = '0;
          col_d  = '0;
          if (rsub_q == SUBW'(SCALE - 1)) begin
            rsub_d = '0;
            row_d  = row_q + RW'(1);
            if (row_q == RW'(HEIGHT - 1)) begin
              fv_d[side_q] = 1'b1;
              cap_d        = C_IDLE;
            end
          end else begin
            rsub_d = rsub_q + SUBW'(1);
          end
        end else if (vs_rise) begin
          drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
          cap_d  = C_IDLE;
        end
      end
      default: cap_d = C_IDLE;
    endcase
  end

  always_comb begin
    rst_d   = rst_q;
    raddr_d = raddr_q;
    rcol_d  = rcol_q;
    rrow_d  = rrow_q;
    unique case (rst_q)
      R_IDLE: begin
        if (rd_accept) begin
          rst_d   = R_ROW;
          raddr_d = (image_sel == SIDE_LEFT) ? AW'(0) : AW'(FRAME);
          rcol_d  = '0;
          rrow_d  = '0;
        end
      end
      R_ROW: begin
        raddr_d = raddr_q + AW'(1);
        if (rcol_q == CW'(WIDTH - 1)) begin
          rcol_d = '0;
          if (rrow_q == RW'(HEIGHT - 1)) begin
            rst_d = R_DONE;
          end else begin
            rrow_d = rrow_q + RW'(1);
            rst_d  = R_GAP;
          end
        end else begin
          rcol_d = rcol_q + CW'(1);
        end
      end
      R_GAP:   rst_d = R_ROW;
      R_DONE:  rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q   <= C_IDLE;
      side_q  <= 1'b0;
      csub_q  <= '0;
      rsub_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      fv_q    <= '0;
      drop_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      rst_q   <= R_IDLE;
      raddr_q <= '0;
      rcol_q  <= '0;
      rrow_q  <= '0;
      ready_q <= 1'b0;
      vref_q  <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      side_q  <= side_d;
      csub_q  <= csub_d;
      rsub_q  <= rsub_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fv_q    <= fv_d;
      drop_q  <= drop_d;
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      rst_q   <= rst_d;
      raddr_q <= raddr_d;
      rcol_q  <= rcol_d;
      rrow_q  <= rrow_d;
      // Qualifiers trail the read state by the RAM latency
      ready_q <= (rst_q == R_ROW);
      vref_q  <= (rst_q == R_ROW) || (rst_q == R_GAP);
    end
  end

  stereo_frame_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(waddr),
    .wdata_i(cam_data),
    .raddr_i(raddr_q),
    .rdata_o(rdata)
  );

  assign image_data   = ready_q ? rdata : 8'd0;
  assign buffer_ready = ready_q;
  assign buffer_href  = ready_q;
  assign buffer_vref  = vref_q;
  assign frame_valid  = fv_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_stereo_frame_feeder.sv
// Directed and randomized bench for stereo_frame_feeder on an 8x8 source,
// SCALE=2, checked against a frame-level reference model.
module tb_stereo_frame_feeder;

  localparam int SW = 8;
  localparam int SH = 8;
  localparam int S  = 2;
  localparam int W  = SW / S;
  localparam int H  = SH / S;
  localparam int N  = W * H;

  logic       clk, reset;
  logic       cam_vsync, cam_href, cam_valid, cam_side;
  logic [7:0] cam_data;
  logic       image_sel, rd_req;
  logic [7:0] image_data;
  logic       buffer_ready, buffer_href, buffer_vref, rd_busy;
  logic [1:0] frame_valid;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int ref_img [2][N];
  bit m_fv [2];
  int m_drop = 0;

  stereo_frame_feeder #(
    .SRC_WIDTH (SW),
    .SRC_HEIGHT(SH),
    .SCALE     (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_valid   (cam_valid),
    .cam_data    (cam_data),
    .cam_side    (cam_side),
    .image_sel   (image_sel),
    .rd_req      (rd_req),
    .image_data  (image_data),
    .buffer_ready(buffer_ready),
    .buffer_href (buffer_href),
    .buffer_vref (buffer_vref),
    .frame_valid (frame_valid),
    .rd_busy     (rd_busy),
    .drop_cnt    (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic status();
    chk("frame_valid", 32'(frame_valid), {30'd0, m_fv[1], m_fv[0]});
    chk("drop_cnt", 32'(drop_cnt), m_drop);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_data"}, 32'(image_data), 0);
    chk({tag, "_ready"}, 32'(buffer_ready), 0);
    chk({tag, "_href"}, 32'(buffer_href), 0);
    chk({tag, "_vref"}, 32'(buffer_vref), 0);
    chk({tag, "_fv"}, 32'(frame_valid), 0);
    chk({tag, "_busy"}, 32'(rd_busy), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
  endtask

  // mode 0: row*SW+col, mode 1: 100+row*SW+col, else random pixels
  task automatic send_frame(input bit side, input int mode,
                            input int nlines, input bit cap);
    int img [N];
    int c, extra, px;
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    cam_side  = side;
    cam_vsync = 1'b0;
    @(negedge clk);
    cam_side = 1'($urandom);
    for (int r = 0; r < nlines; r++) begin
      c = 0;
      extra = $urandom_range(0, 2);
      cam_href = 1'b1;
      while (c < SW + extra) begin
        if ($urandom_range(0, 3) == 0) begin
          cam_valid = 1'b0;
          cam_data  = 8'($urandom);
        end else begin
          case (mode)
            0: px = r * SW + c;
            1: px = 100 + r * SW + c;
            default: px = $urandom_range(0, 255);
          endcase
          if (c >= SW) px = $urandom_range(0, 255);
          cam_valid = 1'b1;
          cam_data  = 8'(px);
          if (c < SW && r % S == 0 && c % S == 0)
            img[(r / S) * W + c / S] = px;
          c++;
        end
        @(negedge clk);
      end
      cam_valid = 1'b0;
      cam_href  = 1'b0;
      repeat (2) @(negedge clk);
    end
    cam_vsync = 1'b1;
    @(negedge clk);
    if (cap) begin
      m_fv[side] = (nlines == SH);
      if (nlines == SH)
        for (int i = 0; i < N; i++) ref_img[side][i] = img[i];
    end
    if (!cap || nlines < SH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
  endtask

  task automatic do_read(input bit sel, input bit acc);
    int first, last, n, vcnt, bcnt, hmis;
    bit busyv [64];
    first = -1; last = -1; n = 0; vcnt = 0; bcnt = 0; hmis = 0;
    image_sel = sel;
    rd_req    = 1'b1;
    @(negedge clk);
    rd_req    = 1'b0;
    image_sel = 1'($urandom);
    for (int k = 1; k <= N + H + 6; k++) begin
      busyv[k] = rd_busy;
      if (rd_busy) bcnt++;
      if (buffer_ready) begin
        if (first < 0) first = k;
        last = k;
        if (n < N) chk("pix", 32'(image_data), ref_img[sel][n]);
        n++;
      end
      if (buffer_vref) vcnt++;
      if (buffer_href !== buffer_ready) hmis++;
      @(negedge clk);
    end
    chk("href_eq_ready", hmis, 0);
    chk("n_pix", n, acc ? N : 0);
    if (acc) begin
      chk("busy_start", 32'(busyv[1]), 1);
      chk("first_ready", first, 2);
      chk("last_ready", last, N + H);
      chk("vref_len", vcnt, N + H - 1);
      chk("busy_last", (last > 0) ? 32'(busyv[last]) : 0, 1);
      chk("busy_drop", (last > 0) ? 32'(busyv[last + 1]) : 1, 0);
    end else begin
      chk("busy_cnt", bcnt, 0);
      chk("vref_cnt", vcnt, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_valid = 1'b0;
    cam_data = 8'd0; cam_side = 1'b0;
    image_sel = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    // Left ramp frame, read back
    send_frame(1'b0, 0, SH, 1'b1);
    status();
    do_read(1'b0, 1'b1);

    // Right side empty: request ignored
    do_read(1'b1, 1'b0);
    status();

    // Right frame, both sides valid
    send_frame(1'b1, 1, SH, 1'b1);
    status();
    do_read(1'b1, 1'b1);
    do_read(1'b0, 1'b1);

    // Frame start during readout is dropped
    fork
      do_read(1'b0, 1'b1);
      begin
        repeat (2) @(negedge clk);
        send_frame(1'b1, 2, SH, 1'b0);
      end
    join
    status();
    do_read(1'b1, 1'b1);
    do_read(1'b0, 1'b1);

    // Frame start and rd_req in the same cycle: readout wins
    fork
      send_frame(1'b0, 2, SH, 1'b0);
      begin
        repeat (2) @(negedge clk);
        do_read(1'b1, 1'b1);
      end
    join
    status();
    do_read(1'b0, 1'b1);

    // Truncated frame after 5 lines
    send_frame(1'b0, 2, 5, 1'b1);
    status();
    do_read(1'b0, 1'b0);

    // Capture of left does not block readout of right
    fork
      send_frame(1'b0, 2, SH, 1'b1);
      begin
        repeat (8) @(negedge clk);
        do_read(1'b1, 1'b1);
        do_read(1'b0, 1'b0);
      end
    join
    status();
    do_read(1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      automatic bit sd = 1'($urandom);
      send_frame(sd, 2, SH, 1'b1);
      status();
      do_read(sd, 1'b1);
    end

    // Reset in the middle of a readout
    image_sel = 1'b0;
    rd_req    = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_mid", 32'(rd_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid");
    reset = 1'b0;
    m_fv[0] = 1'b0;
    m_fv[1] = 1'b0;
    m_drop  = 0;
    @(negedge clk);
    status();
    do_read(1'b0, 1'b0);
    do_read(1'b1, 1'b0);
    send_frame(1'b1, 2, SH, 1'b1);
    status();
    do_read(1'b1, 1'b1);
    do_read(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
